// File: rtl/axi_multiport_bridge.sv
// Bridges NUM_PORTS sram-like masters onto a single AXI3 master with round-robin arbitration,
// per-port outstanding-read limits and a read-after-write address hazard check.
module axi_multiport_bridge #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned RD_OT     = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [NUM_PORTS-1:0]    wr,
  input  logic [2*NUM_PORTS-1:0]  size,
  input  logic [4*NUM_PORTS-1:0]  wstrb,
  input  logic [32*NUM_PORTS-1:0] addr,
  input  logic [32*NUM_PORTS-1:0] wdata,
  output logic [NUM_PORTS-1:0]    addr_ok,
  output logic [NUM_PORTS-1:0]    data_ok,
  output logic [32*NUM_PORTS-1:0] rdata,
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [3:0]              rid,
  input  logic [31:0]             axi_rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [3:0]              awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [3:0]              wid,
  output logic [31:0]             axi_wdata,
  output logic [3:0]              axi_wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [3:0]           rd_cnt [NUM_PORTS];
  logic [29:0]          wtab   [NUM_PORTS];
  logic [NUM_PORTS-1:0] wr_busy, hazard, elig, grant, r_hit, b_hit;
  logic [PW-1:0]        rr_ptr, gidx, cand, rr_next;
  logic                 found, ar_free, aw_free;
  logic                 g_wr;
  logic [31:0]          g_addr, g_wdata;
  logic [1:0]           g_size;
  logic [3:0]           g_wstrb;
  logic                 unused_resp;

  assign arlen   = '0;
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign awlen   = '0;
  assign awburst = 2'b01;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign wlast   = 1'b1;
  assign rready  = 1'b1;
  assign bready  = 1'b1;
  assign unused_resp = ^{rresp, rlast, bresp};

  assign ar_free = !arvalid || arready;
  assign aw_free = !awvalid && !wvalid;

  // A read must wait while any in-flight write targets the same word.
  always_comb begin
    hazard = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++)
      for (int unsigned j = 0; j < NUM_PORTS; j++)
        if (wr_busy[j] && wtab[j] == addr[32*i+2 +: 30]) hazard[i] = 1'b1;
  end

  always_comb begin
    elig  = '0;
    r_hit = '0;
    b_hit = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      r_hit[i] = rvalid && (rid == 4'(i));
      b_hit[i] = bvalid && (bid == 4'(i));
      elig[i]  = req[i] && !wr_busy[i] &&
                 (wr[i] ? (aw_free && rd_cnt[i] == '0)
                        : (ar_free && rd_cnt[i] < 4'(RD_OT) && !hazard[i]));
    end
  end

  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = PW'((32'(rr_ptr) + k) % NUM_PORTS);
      if (!found && elig[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    if (found && resetn) grant[gidx] = 1'b1;
  end

  assign addr_ok = grant;
  assign rr_next = (gidx == PW'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;
  assign g_wr    = wr[gidx];
  assign g_addr  = addr[32*gidx +: 32];
  assign g_wdata = wdata[32*gidx +: 32];
  assign g_size  = size[2*gidx +: 2];
  assign g_wstrb = wstrb[4*gidx +: 4];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid   <= 1'b0;
      arid      <= '0;
      araddr    <= '0;
      arsize    <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      awid      <= '0;
      awaddr    <= '0;
      awsize    <= '0;
      wid       <= '0;
      axi_wdata <= '0;
      axi_wstrb <= '0;
      rr_ptr    <= '0;
      wr_busy   <= '0;
      data_ok   <= '0;
      rdata     <= '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        rd_cnt[i] <= '0;
        wtab[i]   <= '0;
      end
    end else begin
      if (arready) arvalid <= 1'b0;
      if (awready) awvalid <= 1'b0;
      if (wready)  wvalid  <= 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        data_ok[i] <= r_hit[i] || b_hit[i];
        if (r_hit[i]) rdata[32*i +: 32] <= axi_rdata;
        if (b_hit[i]) wr_busy[i] <= 1'b0;
        if ((grant[i] && !wr[i]) && !r_hit[i])      rd_cnt[i] <= rd_cnt[i] + 1'b1;
        else if (!(grant[i] && !wr[i]) && r_hit[i]) rd_cnt[i] <= rd_cnt[i] - 1'b1;
      end
      if (found) begin
        rr_ptr <= rr_next;
        if (g_wr) begin
          awvalid       <= 1'b1;
          wvalid        <= 1'b1;
          awid          <= 4'(gidx);
          wid           <= 4'(gidx);
          awaddr        <= g_addr;
          awsize        <= {1'b0, g_size};
          axi_wdata     <= g_wdata;
          axi_wstrb     <= g_wstrb;
          wr_busy[gidx] <= 1'b1;
          wtab[gidx]    <= g_addr[31:2];
        end else begin
          arvalid <= 1'b1;
          arid    <= 4'(gidx);
          araddr  <= g_addr;
          arsize  <= {1'b0, g_size};
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_multiport_bridge.sv
// Self-checking bench for axi_multiport_bridge (2 ports, RD_OT=2): vector table plus
// directed multi-cycle sequences, with a scoreboard of expected data_ok/rdata per port.
module tb_axi_multiport_bridge;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NP-1:0]    req, wr, addr_ok, data_ok;
  logic [2*NP-1:0]  size;
  logic [4*NP-1:0]  wstrb;
  logic [32*NP-1:0] addr, wdata, rdata;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, axi_wstrb;
  logic [31:0] araddr, awaddr, axi_rdata, axi_wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready;

  axi_multiport_bridge #(.NUM_PORTS(NP), .RD_OT(2)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .axi_rdata(axi_rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        w;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [3:0]  st;
    logic [31:0] d;
  } vec_t;

  typedef struct {
    int          port;
    logic        w;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every data_ok pulse must match the oldest outstanding entry of its port.
  always @(negedge clk) begin : mon
    int idx;
    if (resetn) begin
      for (int p = 0; p < NP; p++) begin
        if (data_ok[p]) begin
          idx = -1;
          for (int k = 0; k < sb.size(); k++)
            if (idx < 0 && sb[k].port == p) idx = k;
          if (idx < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_data_ok: port %0d got data_ok=1 expected 0", p);
          end else begin
            if (!sb[idx].w) chk("sb_rdata", rdata[32*p +: 32], sb[idx].d);
            sb.delete(idx);
          end
        end
      end
    end
  end

  task automatic idle();
    req = '0; wr = '0; size = '0; wstrb = '0; addr = '0; wdata = '0;
    arready = 1'b0; rvalid = 1'b0; rid = '0; axi_rdata = '0; rresp = '0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    idle();
    sb.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic set_port(input int p, input logic w, input logic [31:0] a, input logic [1:0] sz,
                          input logic [3:0] st, input logic [31:0] d);
    req[p] = 1'b1;
    wr[p] = w;
    addr[32*p +: 32] = a;
    size[2*p +: 2] = sz;
    wstrb[4*p +: 4] = st;
    wdata[32*p +: 32] = d;
  endtask

  // Returns at the negedge after acceptance with req[p] dropped.
  task automatic wait_ok(input int p, input string nm);
    int n = 0;
    #1;
    while (!addr_ok[p] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, addr_ok[p], 1);
    @(posedge clk);
    @(negedge clk);
    req[p] = 1'b0;
  endtask

  task automatic xact(input vec_t v);
    @(negedge clk);
    set_port(v.port, v.w, v.a, v.sz, v.st, v.d);
    wait_ok(v.port, "vec_accept");
    if (!v.w) begin
      chk("vec_arvalid", arvalid, 1);
      chk("vec_arid", arid, v.port);
      chk("vec_araddr", araddr, v.a);
      chk("vec_arsize", arsize, {1'b0, v.sz});
      chk("vec_arburst", arburst, 2'b01);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk("vec_arvalid_drop", arvalid, 0);
      rvalid = 1'b1; rid = 4'(v.port); axi_rdata = v.d;
      sb.push_back('{v.port, 1'b0, v.d});
    end else begin
      chk("vec_awvalid", awvalid, 1);
      chk("vec_wvalid", wvalid, 1);
      chk("vec_awid", awid, v.port);
      chk("vec_wid", wid, v.port);
      chk("vec_awaddr", awaddr, v.a);
      chk("vec_awsize", awsize, {1'b0, v.sz});
      chk("vec_wdata", axi_wdata, v.d);
      chk("vec_wstrb", axi_wstrb, v.st);
      awready = 1'b1; wready = 1'b1;
      @(negedge clk);
      awready = 1'b0; wready = 1'b0;
      chk("vec_aw_w_drop", {awvalid, wvalid}, 0);
      bvalid = 1'b1; bid = 4'(v.port);
      sb.push_back('{v.port, 1'b1, 32'h0});
    end
    @(negedge clk);
    rvalid = 1'b0;
    bvalid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    vt[0] = '{0, 1'b0, 32'h0000_1000, 2'd2, 4'hf, 32'hdead_beef};
    vt[1] = '{1, 1'b0, 32'h2000_0003, 2'd0, 4'h8, 32'h1234_5678};
    vt[2] = '{1, 1'b1, 32'h3000_0004, 2'd2, 4'hf, 32'hcafe_f00d};
    vt[3] = '{0, 1'b1, 32'h3000_0102, 2'd1, 4'hc, 32'h5555_aaaa};
    vt[4] = '{0, 1'b0, 32'h4000_0002, 2'd1, 4'h3, 32'h0bad_cafe};
    vt[5] = '{1, 1'b0, 32'hffff_fffc, 2'd2, 4'hf, 32'h8000_0001};

    idle();
    // Reset state, with requests asserted to show addr_ok is held low.
    set_port(0, 1'b0, 32'h10, 2'd2, 4'h0, 32'h0);
    set_port(1, 1'b1, 32'h20, 2'd2, 4'hf, 32'h1);
    @(negedge clk);
    #1;
    chk("rst_addr_ok", addr_ok, 0);
    chk("rst_valids", {arvalid, awvalid, wvalid}, 0);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_rdata_lo", rdata[31:0], 0);
    chk("rst_rdata_hi", rdata[63:32], 0);
    do_reset();

    for (int i = 0; i < 6; i++) xact(vt[i]);

    // T1: reset while a read is pending on AR.
    @(negedge clk);
    set_port(0, 1'b0, 32'h0000_0100, 2'd2, 4'h0, 32'h0);
    wait_ok(0, "t1_accept");
    chk("t1_arvalid_pending", arvalid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t1_arvalid_reset", arvalid, 0);
    chk("t1_data_ok_reset", data_ok, 0);
    chk("t1_rdata_reset", rdata[63:32], 0);
    @(negedge clk);
    idle();
    sb.delete();
    resetn = 1'b1;
    @(negedge clk);
    set_port(0, 1'b1, 32'h0000_0200, 2'd2, 4'hf, 32'h1);
    #1;
    chk("t1_rdcnt_cleared", addr_ok[0], 1);
    req = '0;

    // T2: round-robin alternation with both ports reading every cycle.
    do_reset();
    @(negedge clk);
    set_port(0, 1'b0, 32'h0000_0500, 2'd2, 4'h0, 32'h0);
    set_port(1, 1'b0, 32'h0000_0600, 2'd2, 4'h0, 32'h0);
    arready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t2_grant", addr_ok, (c % 2 == 1) ? 2'b10 : 2'b01);
      @(negedge clk);
      chk("t2_arid", arid, c % 2);
      chk("t2_araddr", araddr, (c % 2 == 1) ? 32'h600 : 32'h500);
    end
    #1;
    chk("t2_ot_limit", addr_ok, 0);
    req = '0;
    @(negedge clk);
    arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; rid = 4'(k % 2); axi_rdata = 32'ha000_0000 + k;
      sb.push_back('{k % 2, 1'b0, 32'ha000_0000 + k});
      @(negedge clk);
    end
    rvalid = 1'b0;
    @(negedge clk);

    // T3: port 1 capped at two outstanding reads until the first returns.
    set_port(1, 1'b0, 32'h0000_0700, 2'd2, 4'h0, 32'h0);
    arready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_ot_gate", addr_ok[1], (c < 2) ? 1 : 0);
      @(negedge clk);
    end
    rvalid = 1'b1; rid = 4'd1; axi_rdata = 32'hb000_0001;
    sb.push_back('{1, 1'b0, 32'hb000_0001});
    #1;
    chk("t3_still_full", addr_ok[1], 0);
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    chk("t3_freed", addr_ok[1], 1);
    @(negedge clk);
    req = '0;
    for (int k = 2; k < 4; k++) begin
      rvalid = 1'b1; rid = 4'd1; axi_rdata = 32'hb000_0000 + k;
      sb.push_back('{1, 1'b0, 32'hb000_0000 + k});
      @(negedge clk);
    end
    rvalid = 1'b0;
    arready = 1'b0;
    @(negedge clk);

    // T4: read-after-write hazard on the same word.
    set_port(1, 1'b1, 32'h1000_0010, 2'd2, 4'hf, 32'h0000_0077);
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    wait_ok(1, "t4_wr_accept");
    set_port(0, 1'b0, 32'h1000_0012, 2'd1, 4'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_hazard_stall", addr_ok[0], 0);
      @(negedge clk);
    end
    addr[31:0] = 32'h1000_0020;
    #1;
    chk("t4_other_addr", addr_ok[0], 1);
    @(negedge clk);
    chk("t4_other_araddr", araddr, 32'h1000_0020);
    addr[31:0] = 32'h1000_0012;
    bvalid = 1'b1; bid = 4'd1;
    sb.push_back('{1, 1'b1, 32'h0});
    #1;
    chk("t4_stall_at_b", addr_ok[0], 0);
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    chk("t4_after_b", addr_ok[0], 1);
    @(negedge clk);
    req = '0;
    chk("t4_araddr", araddr, 32'h1000_0012);
    for (int k = 0; k < 2; k++) begin
      rvalid = 1'b1; rid = 4'd0; axi_rdata = 32'hc000_0000 + k;
      sb.push_back('{0, 1'b0, 32'hc000_0000 + k});
      @(negedge clk);
    end
    rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    @(negedge clk);

    // T5: W channel back-pressure blocks any new write.
    set_port(0, 1'b1, 32'h2000_0000, 2'd2, 4'h3, 32'h0000_1111);
    awready = 1'b1; wready = 1'b0;
    wait_ok(0, "t5_wr0_accept");
    set_port(1, 1'b1, 32'h2000_0100, 2'd2, 4'hf, 32'h0000_2222);
    for (int c = 0; c < 4; c++) begin
      chk("t5_awvalid", awvalid, (c == 0) ? 1 : 0);
      chk("t5_wvalid", wvalid, 1);
      #1;
      chk("t5_no_new_write", addr_ok[1], 0);
      if (c == 3) wready = 1'b1;
      @(negedge clk);
    end
    chk("t5_wvalid_done", wvalid, 0);
    #1;
    chk("t5_next_write", addr_ok[1], 1);
    @(negedge clk);
    req = '0;
    chk("t5_awid1", awid, 1);
    chk("t5_wdata1", axi_wdata, 32'h0000_2222);
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bid = 4'd0;
    sb.push_back('{0, 1'b1, 32'h0});
    @(negedge clk);
    bid = 4'd1;
    sb.push_back('{1, 1'b1, 32'h0});
    @(negedge clk);
    bvalid = 1'b0;
    @(negedge clk);

    // T6: simultaneous read return and write completion on different ports.
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    set_port(0, 1'b0, 32'h3000_0000, 2'd2, 4'h0, 32'h0);
    wait_ok(0, "t6_rd_accept");
    set_port(1, 1'b1, 32'h3000_1000, 2'd2, 4'hf, 32'h0000_0099);
    wait_ok(1, "t6_wr_accept");
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd0; axi_rdata = 32'hfeed_0006;
    bvalid = 1'b1; bid = 4'd1;
    sb.push_back('{0, 1'b0, 32'hfeed_0006});
    sb.push_back('{1, 1'b1, 32'h0});
    @(negedge clk);
    rvalid = 1'b0; bvalid = 1'b0;
    chk("t6_both_data_ok", data_ok, 2'b11);
    chk("t6_rdata0", rdata[31:0], 32'hfeed_0006);
    @(negedge clk);

    // Responses carrying an ID beyond the port range are dropped.
    rvalid = 1'b1; rid = 4'd5; axi_rdata = 32'h5555_5555;
    @(negedge clk);
    rvalid = 1'b0;
    chk("rid_out_of_range", data_ok, 0);
    chk("rid_oor_rdata", rdata[31:0], 32'hfeed_0006);
    @(negedge clk);
    @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
